// File: rtl/axi_stream_dequant_dezigzag_pkg.sv
// Shared definitions for the dequantise / de-zigzag stage.
//  - default coefficient, quant-table and output widths
//  - ZZ2RASTER: zigzag scan index -> raster index (row*8+col)
//  - saturate(): clamps a wide signed value to a w-bit signed range
package axi_stream_dequant_dezigzag_pkg;

  localparam int DEF_WCOEF = 12;
  localparam int DEF_WQT   = 8;
  localparam int DEF_WDQ   = 16;

  localparam int ZZ2RASTER [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  // Clamp v into [-2^(w-1), 2^(w-1)-1]; callers size the result down to w bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/axi_stream_dequant_dezigzag_if.sv
// AXI-stream style data channel (tdata/tvalid/tready).
//  master modport: drives tdata/tvalid, samples tready
//  slave  modport: samples tdata/tvalid, drives tready
interface axi_stream_dequant_dezigzag_if
  import axi_stream_dequant_dezigzag_pkg::*;
#(
  parameter int W = DEF_WDQ
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axi_stream_dequant_dezigzag_dq_saturate.sv
// Combinational dequantiser: signed coefficient x unsigned table entry,
// clamped to a WDQ-bit signed result.
//  coef  in  WCOEF  signed quantised coefficient
//  qt    in  WQT    unsigned quant-table entry (0 forces a 0 result)
//  dq    out WDQ    saturated product
module dq_saturate
  import axi_stream_dequant_dezigzag_pkg::*;
#(
  parameter int WCOEF = DEF_WCOEF,
  parameter int WQT   = DEF_WQT,
  parameter int WDQ   = DEF_WDQ
) (
  input  logic signed [WCOEF-1:0] coef,
  input  logic        [WQT-1:0]   qt,
  output logic signed [WDQ-1:0]   dq
);
  // One extra bit so the zero-extended table entry stays positive.
  localparam int WP = WCOEF + WQT + 1;

  logic signed [WP-1:0] prod;
  logic signed [63:0]   prod_ext;
  logic signed [63:0]   clamped;

  always_comb begin
    prod     = WP'(coef) * WP'($signed({1'b0, qt}));
    prod_ext = 64'(prod);
    clamped  = saturate(prod_ext, WDQ);
    dq       = WDQ'(clamped);
  end
endmodule

// File: rtl/axi_stream_dequant_dezigzag.sv
// Dequantise + de-zigzag stage ahead of the IDCT.
// Coefficients arrive in zigzag order, are multiplied by the matching
// quant-table entry, saturated and written to raster position inside one of
// two 64-entry banks. A full bank is streamed out in raster order while the
// other bank fills.
//  clock, reset  single clock, async active-high reset
//  s_axis        slave channel, WCOEF-bit zigzag coefficients
//  m_axis        master channel, WDQ-bit raster coefficients (0 when idle)
//  qt_we/addr/data  quant-table write port, addr in zigzag order
module axi_stream_dequant_dezigzag
  import axi_stream_dequant_dezigzag_pkg::*;
#(
  parameter int WCOEF = DEF_WCOEF,
  parameter int WQT   = DEF_WQT,
  parameter int WDQ   = DEF_WDQ
) (
  input  logic                          clock,
  input  logic                          reset,
  axi_stream_dequant_dezigzag_if.slave  s_axis,
  axi_stream_dequant_dezigzag_if.master m_axis,
  input  logic                          qt_we,
  input  logic [5:0]                    qt_addr,
  input  logic [WQT-1:0]                qt_data
);
  logic [5:0]     wr_cnt_q, wr_cnt_d;
  logic [5:0]     rd_cnt_q, rd_cnt_d;
  logic           wr_bank_q, wr_bank_d;
  logic           rd_bank_q, rd_bank_d;
  logic [1:0]     full_q, full_d;
  logic [WQT-1:0] qt_q [64];
  logic [WQT-1:0] qt_d [64];
  logic [WDQ-1:0] pp_q [2][64];
  logic [WDQ-1:0] pp_d [2][64];

  logic signed [WDQ-1:0] dq;
  logic [5:0]            wr_idx;
  logic                  acc;
  logic                  pop;

  // Handshakes depend only on registered state, never on the partner's valid/ready.
  assign s_axis.tready = !full_q[wr_bank_q];
  assign acc           = s_axis.tvalid && !full_q[wr_bank_q];
  assign m_axis.tvalid = full_q[rd_bank_q];
  assign m_axis.tdata  = full_q[rd_bank_q] ? pp_q[rd_bank_q][rd_cnt_q] : '0;
  assign pop           = full_q[rd_bank_q] && m_axis.tready;
  assign wr_idx        = 6'(ZZ2RASTER[wr_cnt_q]);

  dq_saturate #(
    .WCOEF (WCOEF),
    .WQT   (WQT),
    .WDQ   (WDQ)
  ) u_dq_saturate (
    .coef (s_axis.tdata),
    .qt   (qt_q[wr_cnt_q]),
    .dq   (dq)
  );

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    qt_d      = qt_q;
    pp_d      = pp_q;

    if (qt_we) qt_d[qt_addr] = qt_data;

    // Writer only ever targets an empty bank and the reader a full one, so a
    // block completing and a block draining in the same cycle touch different
    // full flags.
    if (acc) begin
      pp_d[wr_bank_q][wr_idx] = dq;
      wr_cnt_d = wr_cnt_q + 6'd1;
      if (wr_cnt_q == 6'd63) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end

    if (pop) begin
      rd_cnt_d = rd_cnt_q + 6'd1;
      if (rd_cnt_q == 6'd63) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      for (int i = 0; i < 64; i++) qt_q[i] <= WQT'(1);
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      qt_q      <= qt_d;
    end
  end

  // Bank contents need no reset: the full flags gate every read.
  always_ff @(posedge clock) begin
    pp_q <= pp_d;
  end

endmodule

// File: tb/tb_axi_stream_dequant_dezigzag.sv
module tb_axi_stream_dequant_dezigzag;
  localparam int WC = 12;
  localparam int WQ = 8;
  localparam int WD = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          qt_we;
  logic [5:0]    qt_addr;
  logic [WQ-1:0] qt_data;

  axi_stream_dequant_dezigzag_if #(.W(WC)) s_if ();
  axi_stream_dequant_dezigzag_if #(.W(WD)) m_if ();

  axi_stream_dequant_dezigzag #(.WCOEF(WC), .WQT(WQ), .WDQ(WD)) dut (
    .clock   (clock),
    .reset   (reset),
    .s_axis  (s_if),
    .m_axis  (m_if),
    .qt_we   (qt_we),
    .qt_addr (qt_addr),
    .qt_data (qt_data)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int zz_pos [64];   // zigzag index -> raster index, derived by diagonal walk
  int mqt [64];      // reference copy of the quant table
  int exp_q [$];
  int got_q [$];
  int acc_cyc [$];
  int pop_cyc [$];

  // ---------------- reference model ----------------
  function automatic int model_dq(input int c, input int q);
    int p;
    p = c * q;
    if (p > 32767) return 32767;
    if (p < -32768) return -32768;
    return p;
  endfunction

  function automatic void model_block(input int c [64]);
    int r [64];
    for (int k = 0; k < 64; k++) r[zz_pos[k]] = model_dq(c[k], mqt[k]);
    for (int i = 0; i < 64; i++) exp_q.push_back(r[i]);
  endfunction

  task automatic fill_rand(output int c [64]);
    for (int k = 0; k < 64; k++) c[k] = int'($urandom_range(4095)) - 2048;
  endtask

  task automatic clear_sb();
    exp_q.delete(); got_q.delete(); acc_cyc.delete(); pop_cyc.delete();
  endtask

  // ---------------- drivers (enter and leave on a falling edge) ----------------
  task automatic do_reset();
    reset = 1'b1;
    s_if.tvalid = 1'b0; s_if.tdata = '0; m_if.tready = 1'b0; qt_we = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 64; k++) mqt[k] = 1;
  endtask

  task automatic write_qt(input int a, input int d);
    qt_we = 1'b1; qt_addr = 6'(a); qt_data = WQ'(d);
    @(negedge clock);
    qt_we = 1'b0;
    mqt[a] = d;
  endtask

  task automatic send_n(input int c [64], input int n, input int gap);
    int w;
    for (int k = 0; k < n; k++) begin
      w = 0;
      if (gap > 0 && $urandom_range(99) < gap) begin
        s_if.tvalid = 1'b0;
        @(negedge clock);
      end
      s_if.tvalid = 1'b1;
      s_if.tdata  = WC'(c[k]);
      while (!s_if.tready && w < 2000) begin @(negedge clock); w++; end
      if (w >= 2000) begin
        total++; bad++;
        $display("FAIL send_timeout k=%0d tready stuck low, required high", k);
        s_if.tvalid = 1'b0;
        return;
      end
      acc_cyc.push_back(cyc + 1);
      @(negedge clock);
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic recv_n(input int n, input int rdy);
    int cnt, w;
    cnt = 0; w = 0;
    while (cnt < n && w < 4000) begin
      m_if.tready = ($urandom_range(99) < rdy);
      if (m_if.tvalid && m_if.tready) begin
        got_q.push_back(int'($signed(m_if.tdata)));
        pop_cyc.push_back(cyc + 1);
        cnt++;
      end
      w++;
      @(negedge clock);
    end
    m_if.tready = 1'b0;
    if (cnt < n) begin
      total++; bad++;
      $display("FAIL recv_timeout got=%0d outputs, required %0d", cnt, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total++; if (s_if.tready !== 1'b1) begin bad++; $display("FAIL rst_tready got=%b exp=1", s_if.tready); end
    total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b exp=0", m_if.tvalid); end
    total++; if (m_if.tdata !== '0) begin bad++; $display("FAIL rst_tdata got=%0d exp=0", m_if.tdata); end
  endtask

  task automatic test_identity(input string name);
    int c [64];
    int rr [7] = '{0, 1, 2, 3, 4, 8, 63};
    int rv [7] = '{0, 1, 5, 6, 14, 2, 63};
    clear_sb();
    for (int k = 0; k < 64; k++) c[k] = k;
    model_block(c);
    fork
      send_n(c, 64, 10);
      recv_n(64, 100);
    join
    for (int j = 0; j < 7; j++) begin
      total++;
      if (got_q.size() != 64 || got_q[rr[j]] !== rv[j]) begin
        bad++; $display("FAIL %s_const out[%0d] got=%0d exp=%0d", name, rr[j],
                        (got_q.size() == 64) ? got_q[rr[j]] : -99999, rv[j]);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL %s_data[%0d] got=%0d exp=%0d", name, i,
                        (i < got_q.size()) ? got_q[i] : -99999, exp_q[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int c [64];
    int q0 [3] = '{255, 255, 10};
    int dc [3] = '{2047, -2048, 3};
    int ex [3] = '{32767, -32768, 30};
    for (int j = 0; j < 3; j++) begin
      clear_sb();
      write_qt(0, q0[j]);
      fill_rand(c);
      c[0] = dc[j];
      model_block(c);
      fork
        send_n(c, 64, 25);
        recv_n(64, 75);
      join
      total++;
      if (got_q.size() < 1 || got_q[0] !== ex[j]) begin
        bad++; $display("FAIL sat_dc case%0d got=%0d exp=%0d", j,
                        (got_q.size() > 0) ? got_q[0] : -99999, ex[j]);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL sat_data case%0d [%0d] got=%0d exp=%0d", j, i,
                          (i < got_q.size()) ? got_q[i] : -99999, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_qt_zero();
    int c [64];
    clear_sb();
    write_qt(0, 0);
    fill_rand(c);
    c[0] = 100;
    model_block(c);
    fork
      send_n(c, 64, 0);
      recv_n(64, 100);
    join
    total++;
    if (got_q.size() < 1 || got_q[0] !== 0) begin
      bad++; $display("FAIL qt0_dc got=%0d exp=0", (got_q.size() > 0) ? got_q[0] : -99999);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL qt0_data[%0d] got=%0d exp=%0d", i,
                        (i < got_q.size()) ? got_q[i] : -99999, exp_q[i]);
      end
    end
  endtask

  task automatic test_random_tables();
    int c0 [64], c1 [64], c2 [64];
    clear_sb();
    for (int k = 0; k < 64; k++) write_qt(k, int'($urandom_range(255)));
    fill_rand(c0); fill_rand(c1); fill_rand(c2);
    model_block(c0); model_block(c1); model_block(c2);
    fork
      begin send_n(c0, 64, 30); send_n(c1, 64, 30); send_n(c2, 64, 30); end
      recv_n(192, 60);
    join
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL rnd_data[%0d] got=%0d exp=%0d", i,
                        (i < got_q.size()) ? got_q[i] : -99999, exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int c0 [64], c1 [64], c2 [64];
    do_reset();
    clear_sb();
    fill_rand(c0); fill_rand(c1); fill_rand(c2);
    model_block(c0); model_block(c1); model_block(c2);
    send_n(c0, 64, 20);
    send_n(c1, 64, 20);
    total++; if (s_if.tready !== 1'b0) begin bad++; $display("FAIL bp_full_tready got=%b exp=0", s_if.tready); end
    total++; if (acc_cyc.size() != 128) begin bad++; $display("FAIL bp_accepted got=%0d exp=128", acc_cyc.size()); end
    repeat (4) @(negedge clock);
    total++; if (s_if.tready !== 1'b0) begin bad++; $display("FAIL bp_hold_tready got=%b exp=0", s_if.tready); end
    total++; if (m_if.tvalid !== 1'b1) begin bad++; $display("FAIL bp_hold_tvalid got=%b exp=1", m_if.tvalid); end
    recv_n(64, 100);
    total++; if (s_if.tready !== 1'b1) begin bad++; $display("FAIL bp_release_tready got=%b exp=1", s_if.tready); end
    total++; if (m_if.tvalid !== 1'b1) begin bad++; $display("FAIL bp_second_bank_tvalid got=%b exp=1", m_if.tvalid); end
    fork
      send_n(c2, 64, 0);
      recv_n(128, 70);
    join
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL bp_data[%0d] got=%0d exp=%0d", i,
                        (i < got_q.size()) ? got_q[i] : -99999, exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c0 [64], c1 [64];
    do_reset();
    clear_sb();
    fill_rand(c0); fill_rand(c1);
    model_block(c0); model_block(c1);
    fork
      begin send_n(c0, 64, 0); send_n(c1, 64, 0); end
      recv_n(128, 100);
    join
    total++;
    if (acc_cyc.size() < 64 || pop_cyc.size() < 1 || pop_cyc[0] != acc_cyc[63] + 1) begin
      bad++; $display("FAIL b2b_latency first_out_cycle=%0d required=%0d",
                      (pop_cyc.size() > 0) ? pop_cyc[0] : -1,
                      (acc_cyc.size() >= 64) ? acc_cyc[63] + 1 : -1);
    end
    total++;
    if (pop_cyc.size() != 128 || pop_cyc[127] != pop_cyc[0] + 127) begin
      bad++; $display("FAIL b2b_gapless span=%0d required=127",
                      (pop_cyc.size() == 128) ? pop_cyc[127] - pop_cyc[0] : -1);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL b2b_data[%0d] got=%0d exp=%0d", i,
                        (i < got_q.size()) ? got_q[i] : -99999, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midblock();
    int c [64];
    do_reset();
    clear_sb();
    write_qt(3, 9);
    fill_rand(c);
    send_n(c, 64, 0);     // one full bank, nobody reading
    send_n(c, 30, 0);     // partial block in the other bank
    reset = 1'b1;
    #1;
    total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL midrst_tvalid got=%b exp=0", m_if.tvalid); end
    total++; if (s_if.tready !== 1'b1) begin bad++; $display("FAIL midrst_tready got=%b exp=1", s_if.tready); end
    total++; if (m_if.tdata !== '0) begin bad++; $display("FAIL midrst_tdata got=%0d exp=0", m_if.tdata); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 64; k++) mqt[k] = 1;
    @(negedge clock);
    total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL midrst_after_tvalid got=%b exp=0", m_if.tvalid); end
    test_identity("midrst");
  endtask

  initial begin
    int k;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 1) begin
        for (int r = lo; r <= hi; r++) begin zz_pos[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = hi; r >= lo; r--) begin zz_pos[k] = r * 8 + (s - r); k++; end
      end
    end
    reset = 1'b0; qt_we = 1'b0; qt_addr = '0; qt_data = '0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; m_if.tready = 1'b0;
    #1 reset = 1'b1;
    @(negedge clock);

    test_reset();
    test_identity("ident");
    test_saturation();
    test_qt_zero();
    test_random_tables();
    test_backpressure();
    test_back_to_back();
    test_reset_midblock();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
